// File: rtl/vr_fifo_drain.sv
// vr_fifo_drain: pops an upstream vr_fifo into a 2-entry skid buffer
// and presents it on a registered valid/ready port. Stats: VR_FIFO_DRAIN_STATS_EN.
module vr_fifo_drain #(
    parameter int DATA_WIDTH = 32
`ifdef VR_FIFO_DRAIN_STATS_EN
    ,
    parameter int COUNT_WIDTH = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rdEn,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef VR_FIFO_DRAIN_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0] beat_count
`endif
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;
    logic                  pop;
    logic                  acc;

    // Pop request never looks at out_ready, so the ready path stays registered.
    always_comb begin
        fifo_rdEn = !fifo_empty && (state != TWO) && !flush && !reset;
        pop       = fifo_rdEn;
        out_valid = (state != EMPTY);
        out_data  = slot0;
        acc       = out_valid && out_ready;
    end

    // Skid-buffer state machine: slot0 feeds the output, slot1 absorbs stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (pop) begin
                        state <= ONE;
                        slot0 <= fifo_read_data;
                    end
                end
                ONE: begin
                    if (pop && acc) begin
                        slot0 <= fifo_read_data;
                    end else if (pop) begin
                        state <= TWO;
                        slot1 <= fifo_read_data;
                    end else if (acc) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (acc) begin
                        state <= ONE;
                        slot0 <= slot1;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef VR_FIFO_DRAIN_STATS_EN
    // Saturating count of delivered beats; a flush does not undo delivery.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_count <= '0;
        end else if (acc && (beat_count != {COUNT_WIDTH{1'b1}})) begin
            beat_count <= beat_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/vr_fifo_drain.md
Name: vr_fifo_drain

Overview:
- Consumer end of the vr_fifo read interface.
- Pops entries from an upstream vr_fifo using its empty/rdEn/read_data signals, and presents them on a registered valid/ready output port.
- A 2-entry internal skid buffer breaks the combinational path from downstream ready to upstream rdEn, so full throughput is kept.
- Placed between issue/dispatch queues and consumers in the out-of-order core.

Parameters:
- DATA_WIDTH, 32, width of each FIFO entry and of out_data.
- COUNT_WIDTH, 16, width of beat_count. Used only when VR_FIFO_DRAIN_STATS_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- fifo_read_data  input  DATA_WIDTH  head entry of the upstream FIFO. Valid combinationally while fifo_empty=0.
- fifo_empty  input  1  upstream FIFO empty flag.
- fifo_rdEn  output  1  pop request to the upstream FIFO. The head is consumed at the same rising edge.
- flush  input  1  discards all buffered entries.
- out_data  output  DATA_WIDTH  data beat to the downstream consumer.
- out_valid  output  1  out_data holds a beat.
- out_ready  input  1  downstream accepts the beat this cycle.
- beat_count  output  COUNT_WIDTH  accepted-beat counter. Present only with VR_FIFO_DRAIN_STATS_EN.

Behaviour:
- Storage: two registers, slot0 (output, drives out_data) and slot1 (skid).
- State machine:
  - EMPTY: 0 entries.
  - ONE: slot0 valid.
  - TWO: slot0 and slot1 valid.
- Outputs:
  - out_valid = (state != EMPTY).
  - out_data = slot0 (registered).
- Pop rule: fifo_rdEn = !fifo_empty && state != TWO && !flush && !reset. It is combinational from registered state, fifo_empty and flush only. It never depends on out_ready.
- pop = fifo_rdEn. The popped value is fifo_read_data sampled at the same edge.
- acc = out_valid && out_ready.
- Transitions (no flush):
  - EMPTY: pop -> ONE, slot0 <= data.
  - ONE, pop && acc: stay ONE, slot0 <= data.
  - ONE, pop && !acc: -> TWO, slot1 <= data.
  - ONE, !pop && acc: -> EMPTY.
  - ONE, otherwise: stay ONE, slot0 unchanged.
  - TWO, acc: -> ONE, slot0 <= slot1. No pop occurs in TWO.
  - TWO, !acc: hold. out_data stays stable while out_valid=1 and out_ready=0.
- Latency: a word at the FIFO head with state EMPTY appears on out_data/out_valid one cycle after the pop edge.
- Throughput: one beat per cycle sustained with out_ready held high.
- Ordering: strict FIFO order; no duplication, no loss except on flush.
- Flush (synchronous):
  - Forces state <= EMPTY. No pop that cycle.
  - out_valid = 0 from the next cycle.
  - An acc in the flush cycle still counts as delivered.
  - Flush has priority over pop.
- Reset:
  - state=EMPTY, out_valid=0, out_data=0, slot1=0, fifo_rdEn=0, beat_count=0.
  - Reset mid-stream drops buffered entries.
  - Upstream FIFO contents are untouched, because no pop occurs during reset.
- fifo_empty=1: fifo_rdEn=0 unconditionally. fifo_read_data is ignored (it may be X).
- Never pops more than two entries ahead of the consumer.

Optional Feature:
- Macro: VR_FIFO_DRAIN_STATS_EN.
- Defined:
  - beat_count port exists.
  - Increments by 1 on each acc.
  - Saturates at 2^COUNT_WIDTH-1.
  - Cleared by reset only; flush does not clear it.
- Undefined: beat_count port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset for 10 cycles with fifo_empty=1 -> out_valid=0, out_data=0, fifo_rdEn=0 throughout; beat_count=0.
- FIFO holds 100; out_ready=1 -> fifo_rdEn=1 in cycle 0; out_valid=1 with out_data=100 in cycle 1; state EMPTY and out_valid=0 in cycle 2.
- FIFO holds 51,78,39,23; out_ready=0 -> exactly two pops (51,78), then fifo_rdEn=0 with out_data=51 held. Then out_ready=1 -> beats 51,78,39,23 on consecutive cycles; beat_count=4 (stats build).
- Back-to-back stream of 8 words with out_ready=1 -> 8 beats in 8 consecutive cycles after the 1-cycle latency, in order.
- State TWO (51 in slot0, 78 in slot1), flush=1 for one cycle with out_ready=0 -> out_valid=0 next cycle. Next pop delivers 39 (not 51/78); beat_count unchanged.
- fifo_read_data=X while fifo_empty=1 -> fifo_rdEn=0, and no X propagates to out_data or out_valid.
